// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with 2-entry skid buffer (optional perf counters: PIPE_STAGE_PERF_EN)
module pipe_stage_skid #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_EN
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_out_valid;
  logic              r_in_ready;

  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Handshake FSM: main holds the head word, skid catches the one word that
  // arrives in the cycle the registered in_ready could not yet react.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main      <= BUBBLE_VAL;
      r_skid      <= BUBBLE_VAL;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_main      <= BUBBLE_VAL;
      r_skid      <= BUBBLE_VAL;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            r_main      <= in_data;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_skid     <= in_data;
            r_state    <= S_FULL;
            r_in_ready <= 1'b0;
          end else if (w_out_fire) begin
            r_main      <= BUBBLE_VAL;
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            r_main     <= r_skid;
            r_skid     <= BUBBLE_VAL;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_main      <= BUBBLE_VAL;
          r_skid      <= BUBBLE_VAL;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_valid ? r_main : BUBBLE_VAL;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating counters for backpressure and empty-output cycles; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (!r_out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  // Counter width is meaningless without the counters; keep the parameter referenced.
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;
  localparam int              DW   = 32;
  localparam logic [DW-1:0]   BV   = 32'h0000_0013;
  localparam int              CW   = 4;
  localparam int              CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BV), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef PIPE_STAGE_PERF_EN
    .out_data(out_data),
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
`else
    .out_data(out_data)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] mq[$];
  int m_stall  = 0;
  int m_bubble = 0;
  logic [DW-1:0] got[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] exp_d;
    exp_d = (mq.size() > 0) ? mq[0] : BV;
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(mq.size() < 2));
    chk({tag, "_out_data"}, 64'(out_data), 64'(exp_d));
`ifdef PIPE_STAGE_PERF_EN
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    chk({tag, "_bubble_cnt"}, 64'(bubble_cnt), 64'(m_bubble));
`endif
  endtask

  // One clock: reference model is a FIFO of at most two words, updated at the edge.
  task automatic tick();
    bit do_upd;
    bit inf;
    bit outf;
    do_upd = !rst;
    inf    = in_valid && (mq.size() < 2);
    outf   = (mq.size() > 0) && out_ready;
    if (do_upd) begin
      if (mq.size() > 0 && !out_ready && m_stall < CMAX) m_stall++;
      if (mq.size() == 0 && m_bubble < CMAX) m_bubble++;
    end
    @(posedge clk);
    if (do_upd) begin
      if (flush) begin
        mq.delete();
      end else begin
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back(in_data);
      end
    end
    #1;
  endtask

  // Reset pulse placed between clock edges; outputs must react without an edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    mq.delete();
    m_stall  = 0;
    m_bubble = 0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    chk("arst_out_data", 64'(out_data), 64'(BV));
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] wa, wb, wc, wd, wx;
    bit acc;

    // reset state
    @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_idle_data", 64'(out_data), 64'(BV));
    #3;
    rst = 1'b0;
    tick();
    check_all("idle");

    // streaming 0..9
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DW'(i);
      tick();
      check_all("stream");
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_ready", 64'(in_ready), 64'(1));
    end
    in_valid = 1'b0;
    tick();
    tick();
    check_all("drain");

    // backpressure A,B then C held upstream
    wa = $urandom; wb = $urandom; wc = $urandom;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = wa;
    tick();
    check_all("bp_a");
    in_data = wb;
    tick();
    check_all("bp_b");
    chk("bp_full_ready", 64'(in_ready), 64'(0));
    chk("bp_head", 64'(out_data), 64'(wa));
    in_data = wc;
    repeat (3) tick();
    check_all("bp_hold");
    chk("bp_stable", 64'(out_data), 64'(wa));
    out_ready = 1'b1;
    got.delete();
    for (int n = 0; n < 8; n++) begin
      if (out_valid && out_ready) got.push_back(out_data);
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      check_all("bp_rel");
    end
    chk("bp_count", 64'(got.size()), 64'(3));
    if (got.size() == 3) begin
      chk("bp_order0", 64'(got[0]), 64'(wa));
      chk("bp_order1", 64'(got[1]), 64'(wb));
      chk("bp_order2", 64'(got[2]), 64'(wc));
    end

    // flush while FULL with D offered
    wd = $urandom;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    tick();
    in_data = $urandom;
    tick();
    chk("fl_full", 64'(in_ready), 64'(0));
    in_data = wd;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_all("fl");
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    chk("fl_out_data", 64'(out_data), 64'(BV));
    chk("fl_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("fl_no_d", 64'(out_valid), 64'(0));
    end

    // async reset mid-stream
    in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_data = $urandom;
      tick();
      check_all("pre_arst");
    end
    in_valid = 1'b0;
    async_reset();
    wx = $urandom;
    in_valid = 1'b1;
    in_data  = wx;
    tick();
    check_all("post_arst");
    chk("post_arst_data", 64'(out_data), 64'(wx));
    in_valid = 1'b0;
    tick();

`ifdef PIPE_STAGE_PERF_EN
    // counters: 3 idle cycles, then 20 stalled cycles saturate at 15
    out_ready = 1'b0;
    async_reset();
    repeat (3) tick();
    chk("bubble3", 64'(bubble_cnt), 64'(3));
    in_valid = 1'b1;
    in_data  = $urandom;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("stall_sat", 64'(stall_cnt), 64'(15));
    check_all("perf");
    out_ready = 1'b1;
`endif

    // randomized traffic with occasional flush
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_data   = $urandom;
      tick();
      check_all("rand");
    end
    flush    = 1'b0;
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
